seq_frame_tx: RTL and testbench
===============================

Name: seq_frame_tx

Overview:
Serial frame transmitter for the 11101 sync-word link. On a start handshake it latches a parallel payload, then drives one bit per clock: the sync word first, then the payload MSB first. It is the transmit end of the bit-serial sync-detect path. Its output feeds the serial sequence detector at the receive end, directly or through the channel.

Parameters:
SYNC_LEN, 5, number of sync bits sent at the head of each frame.
SYNC_WORD, 5'b11101, sync pattern, sent MSB first, width SYNC_LEN.
DATA_W, 8, payload width in bits.
IDLE_BIT, 1'b0, value held on dataout when no frame is being sent.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-high; clock clock.
start  in  1  request to send a frame; accepted on any rising edge where start && ready.
datain  in  DATA_W  payload, sampled only on the accept edge.
ready  out  1  block can accept start this cycle.
dataout  out  1  serial bit, registered.
bit_valid  out  1  dataout carries a frame bit this cycle.
sync_active  out  1  dataout is a sync-word bit.
done  out  1  one-cycle pulse during the last bit of a frame.

Behaviour:
- Reset, synchronous, wins over everything: state=IDLE, bit counter=0, shift register=0. Outputs next cycle: dataout=IDLE_BIT, bit_valid=0, sync_active=0, done=0, ready=1.
- States:
  - IDLE -> SYNC on accept.
  - SYNC -> DATA after bit SYNC_LEN-1.
  - DATA -> IDLE after bit DATA_W-1. With PARITY_EN, DATA -> PARITY instead.
  - PARITY -> IDLE.
  - Any state -> SYNC on accept, per the back-to-back rule below.
- Accept edge: datain latched into the shift register; bit counter cleared.
- Latency: the first sync bit is on dataout in the cycle immediately after the accept edge.
- Frame length F = SYNC_LEN + DATA_W, plus 1 with PARITY_EN. Default F = 13, or 14 with parity.
- SYNC: dataout = SYNC_WORD[SYNC_LEN-1-cnt]; sync_active=1.
- DATA: dataout = shift register MSB; shift left one bit per cycle.
- bit_valid=1 for exactly F consecutive cycles per frame.
- The counter is sized for max(SYNC_LEN, DATA_W) - 1 and clears on every state change; it never wraps inside a state.
- ready = (state==IDLE) || (last bit of frame on dataout).
- Back-to-back: start accepted during the last bit begins the next sync word on the very next cycle. No idle gap; bit_valid stays high.
- start while ready=0: ignored, not queued. datain changes outside the accept edge have no effect.
- done=1 only during the last bit of the frame. Its value is independent of any new accept on that cycle.
- Reset mid-frame: the frame is abandoned, with no done pulse. A start on the reset edge is ignored.
- Held-high start: a new frame is accepted at every frame boundary.

Optional Feature:
PARITY_EN: macro SEQ_FRAME_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and sends one even-parity bit, the XOR of the DATA_W payload bits. bit_valid=1 and sync_active=0 during it; done and ready move to the parity bit.
- Undefined: no PARITY state, F = SYNC_LEN + DATA_W, and no parity logic is synthesised.

Test Plan:
- Reset held 3 cycles with start=1 -> dataout=0, bit_valid=0, ready=1, done=0. No frame starts until start is sampled after reset falls.
- Single frame, datain=8'hA5, start pulsed 1 cycle -> from the next cycle dataout = 1,1,1,0,1,1,0,1,0,0,1,0,1. Also:
  - bit_valid=1 for exactly 13 cycles.
  - sync_active=1 for the first 5 of them.
  - done=1 only on the 13th.
  - ready=1 on the 13th, then stays 1.
- Back-to-back: 8'hFF accepted, then 8'h00 accepted on the done cycle -> 26 contiguous valid bits: 11101 11111111 11101 00000000, with two done pulses 13 cycles apart.
- start=1 with datain=8'h3C pulsed at bit 4 of a frame carrying 8'hA5 -> ignored. The frame completes as 8'hA5 and bit_valid returns to 0.
- Reset asserted at the 7th bit of a frame -> the next cycle dataout=0, bit_valid=0, ready=1, with no done pulse. A start after reset sends a complete fresh frame.
- With SEQ_FRAME_TX_PARITY_EN, datain=8'hA5 -> 14th bit is 0; datain=8'h07 -> 14th bit is 1. done is on the 14th bit, and the frame is 14 bits long.

Source files
------------

// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-output bundle for seq_frame_tx.
//   master : the frame source. It drives start/datain and observes the serial side.
//   slave  : the transmitter. It receives start/datain and drives ready,
//            dataout, bit_valid, sync_active and done.
// Signals:
//   start       request to send a frame (accepted when start && ready)
//   datain      payload, sampled only on the accept edge
//   ready       transmitter can accept start this cycle
//   dataout     registered serial bit
//   bit_valid   dataout carries a frame bit
//   sync_active dataout carries a sync-word bit
//   done        high during the last bit of a frame
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] datain;
  logic              ready;
  logic              dataout;
  logic              bit_valid;
  logic              sync_active;
  logic              done;

  modport master (
    output start, datain,
    input  ready, dataout, bit_valid, sync_active, done
  );

  modport slave (
    input  start, datain,
    output ready, dataout, bit_valid, sync_active, done
  );
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter for the 11101 sync-word link.
// On an accepted start it latches the payload. It then sends one bit per clock:
// first the sync word (MSB first), then the payload (MSB first), and optionally
// an even-parity bit.
// Optional feature: define SEQ_FRAME_TX_PARITY_EN to append a parity bit. The
// parity bit is the XOR of all payload bits.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    seq_frame_tx_if.slave (start, datain in; ready, dataout,
//          bit_valid, sync_active, done out)
module seq_frame_tx #(
  parameter int                  SYNC_LEN  = 5,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 5'b11101,
  parameter int                  DATA_W    = 8,
  parameter logic                IDLE_BIT  = 1'b0
) (
  input logic           clock,
  input logic           reset,
  seq_frame_tx_if.slave bus
);

  localparam int CNT_MAX = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  // The state register tracks the bit currently on dataout.
  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [DATA_W-1:0]   sh_q, sh_n;
  logic                dout_q, dout_n;
  logic [SYNC_LEN-1:0] sync_bits;
  logic                last_bit;
  logic                ready_int;
  logic                accept;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic                par_q, par_n;
`endif

  always_comb begin
`ifdef SEQ_FRAME_TX_PARITY_EN
    last_bit = (state_q == PARITY);
`else
    last_bit = (state_q == DATA) && (cnt_q == DATA_LAST);
`endif
    ready_int = (state_q == IDLE) || last_bit;
    accept    = bus.start && ready_int;
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    sh_n      = sh_q;
    dout_n    = IDLE_BIT;
    sync_bits = '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
    par_n     = par_q;
`endif

    unique case (state_q)
      IDLE: ;
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        sh_n = sh_q << 1;
        if (cnt_q == DATA_LAST) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = IDLE;
`endif
          cnt_n = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      PARITY: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // An accept on the last bit overrides the normal end-of-frame step.
    // This chains the next sync word with no idle gap.
    if (accept) begin
      state_n = SYNC;
      cnt_n   = '0;
      sh_n    = bus.datain;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_n   = ^bus.datain;
`endif
    end

    // dataout is registered, so the next serial bit is computed from the
    // next-state values.
    sync_bits = SYNC_WORD << cnt_n;
    unique case (state_n)
      SYNC:    dout_n = sync_bits[SYNC_LEN-1];
      DATA:    dout_n = sh_n[DATA_W-1];
`ifdef SEQ_FRAME_TX_PARITY_EN
      PARITY:  dout_n = par_q;
`endif
      default: dout_n = IDLE_BIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= IDLE_BIT;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      dout_q  <= dout_n;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign bus.ready       = ready_int;
  assign bus.dataout     = dout_q;
  assign bus.bit_valid   = (state_q != IDLE);
  assign bus.sync_active = (state_q == SYNC);
  assign bus.done        = last_bit;

endmodule

// File: tb/tb_seq_frame_tx.sv
module tb_seq_frame_tx;
  localparam int DATA_W   = 8;
  localparam int SYNC_LEN = 5;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 5'b11101;
`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int F = 14;
`else
  localparam int F = 13;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  seq_frame_tx_if #(.DATA_W(DATA_W)) bus();

  seq_frame_tx #(
    .SYNC_LEN (SYNC_LEN),
    .SYNC_WORD(SYNC_WORD),
    .DATA_W   (DATA_W),
    .IDLE_BIT (1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an accepted frame is expanded into a queue of bits.
  // One bit is shown per cycle.
  typedef struct packed {
    logic b;
    logic s;
    logic last;
  } item_t;

  item_t q[$];
  item_t cur;
  logic  cur_v  = 1'b0;
  logic  chk_en = 1'b0;

  function automatic void push_frame(input logic [DATA_W-1:0] d);
    item_t it;
    for (int i = SYNC_LEN - 1; i >= 0; i--) begin
      it = '{b: SYNC_WORD[i], s: 1'b1, last: 1'b0};
      q.push_back(it);
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      it = '{b: d[i], s: 1'b0, last: 1'b0};
      q.push_back(it);
    end
`ifdef SEQ_FRAME_TX_PARITY_EN
    it = '{b: ^d, s: 1'b0, last: 1'b0};
    q.push_back(it);
`endif
    q[q.size()-1].last = 1'b1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      cur_v = 1'b0;
    end else begin
      if (bus.start && (!cur_v || cur.last)) push_frame(bus.datain);
      if (q.size() > 0) begin
        cur   = q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model.dataout",     32'(bus.dataout),     32'(cur_v ? cur.b : 1'b0));
      chk("model.bit_valid",   32'(bus.bit_valid),   32'(cur_v));
      chk("model.sync_active", 32'(bus.sync_active), 32'(cur_v && cur.s));
      chk("model.done",        32'(bus.done),        32'(cur_v && cur.last));
      chk("model.ready",       32'(bus.ready),       32'(!cur_v || cur.last));
    end
  end

  typedef struct {
    logic r;
    logic s;
    logic [DATA_W-1:0] d;
    logic eo, ev, es, ed, er;
  } vec_t;

  vec_t tbl[$];

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [13:0] a5_bits;
    logic [2*F-1:0] exp_b2b, got_b2b, got_val, got_done, exp_done;
    vec_t v;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.datain = '0;
    @(negedge clock);
    chk_en = 1'b1;

    // Hand-derived A5 frame: sync 11101, payload 10100101, parity 0.
    a5_bits = 14'b11101_10100101_0;
    for (int i = 0; i < 3; i++) begin
      v = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl.push_back(v);
    end
    v = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl.push_back(v);
    for (int i = 0; i < F; i++) begin
      v.r  = 1'b0;
      v.s  = (i == 0) || (i == 4);
      v.d  = (i == 4) ? 8'h3C : 8'hA5;
      v.eo = a5_bits[13-i];
      v.ev = 1'b1;
      v.es = (i < SYNC_LEN);
      v.ed = (i == F - 1);
      v.er = (i == F - 1);
      tbl.push_back(v);
    end
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      reset      = tbl[i].r;
      bus.start  = tbl[i].s;
      bus.datain = tbl[i].d;
      cyc();
      chk($sformatf("vec%0d.dataout", i),   32'(bus.dataout),     32'(tbl[i].eo));
      chk($sformatf("vec%0d.bit_valid", i), 32'(bus.bit_valid),   32'(tbl[i].ev));
      chk($sformatf("vec%0d.sync", i),      32'(bus.sync_active), 32'(tbl[i].es));
      chk($sformatf("vec%0d.done", i),      32'(bus.done),        32'(tbl[i].ed));
      chk($sformatf("vec%0d.ready", i),     32'(bus.ready),       32'(tbl[i].er));
    end

    // Back-to-back: FF, then 00 accepted on the done cycle.
`ifdef SEQ_FRAME_TX_PARITY_EN
    exp_b2b = 28'b11101_11111111_0_11101_00000000_0;
`else
    exp_b2b = 26'b11101_11111111_11101_00000000;
`endif
    exp_done = '0;
    exp_done[F] = 1'b1;
    exp_done[0] = 1'b1;
    bus.start  = 1'b1;
    bus.datain = 8'hFF;
    cyc();
    for (int c = 0; c < 2 * F; c++) begin
      got_b2b[2*F-1-c]  = bus.dataout;
      got_val[2*F-1-c]  = bus.bit_valid;
      got_done[2*F-1-c] = bus.done;
      bus.start  = (c == F - 1);
      bus.datain = (c == F - 1) ? 8'h00 : 8'hFF;
      cyc();
    end
    chk("b2b.bits",  32'(got_b2b),  32'(exp_b2b));
    chk("b2b.valid", 32'(got_val),  32'({(2*F){1'b1}}));
    chk("b2b.done",  32'(got_done), 32'(exp_done));
    chk("b2b.after_valid", 32'(bus.bit_valid), 32'(0));
    cyc();

    // Reset while the 7th bit is on dataout.
    bus.start  = 1'b1;
    bus.datain = 8'hA5;
    cyc();
    bus.start = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    chk("midrst.valid_before", 32'(bus.bit_valid), 32'(1));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst.dataout", 32'(bus.dataout),   32'(0));
    chk("midrst.valid",   32'(bus.bit_valid), 32'(0));
    chk("midrst.ready",   32'(bus.ready),     32'(1));
    chk("midrst.done",    32'(bus.done),      32'(0));
    bus.start  = 1'b1;
    bus.datain = 8'h07;
    cyc();
    bus.start = 1'b0;
    for (int c = 0; c < F - 1; c++) cyc();
    chk("fresh.done_last", 32'(bus.done), 32'(1));
`ifdef SEQ_FRAME_TX_PARITY_EN
    chk("fresh.parity07", 32'(bus.dataout), 32'(1));
`else
    chk("fresh.lastbit07", 32'(bus.dataout), 32'(1));
`endif
    cyc();
    chk("fresh.idle_after", 32'(bus.bit_valid), 32'(0));

    // Randomized traffic. Some stretches hold start high.
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 79) == 0);
      bus.start  = (c % 200 < 60) ? 1'b1 : ($urandom_range(0, 5) == 0);
      bus.datain = DATA_W'($urandom);
      cyc();
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int c = 0; c < F + 2; c++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
